// File: rtl/spike_rate_meter.sv
// Spike-train consumer: counts spike edges per back-to-back window and tracks the
// interval between the two most recent spikes, publishing both through valid/ready.
module spike_rate_meter #(
   parameter int WIN_W = 16,
   parameter int CNT_W = 8,
   parameter int ISI_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             spike,
   input  logic [WIN_W-1:0] win_len,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [CNT_W-1:0] rate,
   output logic [ISI_W-1:0] isi,
   output logic             isi_ok,
   output logic             rate_sat,
   output logic             overrun,
   output logic             busy
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [ISI_W-1:0] ISI_MAX = '1;

   typedef enum logic {S_IDLE, S_COUNT} state_t;

   state_t           r_state, w_state_nxt;
   logic             r_spike_q;
   logic [WIN_W-1:0] r_win_cnt;
   logic [CNT_W-1:0] r_acc;
   logic             r_sat;
   logic [ISI_W-1:0] r_since;
   logic [ISI_W-1:0] r_isi_last;
   logic             r_seen1;
   logic             r_seen2;

   logic             w_event;
   logic             w_last;
   logic             w_restart;
   logic             w_hs;
   logic             w_acc_ovf;
   logic [CNT_W-1:0] w_acc_inc;

   // spike_q resets high so a level already present at reset release is not an edge
   assign w_event   = spike & ~r_spike_q;
   assign w_last    = (r_state == S_COUNT) && (r_win_cnt == WIN_W'(1));
   assign w_hs      = out_valid & out_ready;
   assign w_acc_ovf = w_event & (r_acc == CNT_MAX);
   assign w_acc_inc = w_acc_ovf ? r_acc : r_acc + {{(CNT_W-1){1'b0}}, w_event};
   assign busy      = (r_state == S_COUNT);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // w_restart samples win_len at every window start, including the back-to-back reload
   always_comb begin
      w_state_nxt = r_state;
      w_restart   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (win_len != '0) begin
               w_state_nxt = S_COUNT;
               w_restart   = 1'b1;
            end
         end
         S_COUNT: begin
            if (w_last) begin
               w_restart = 1'b1;
               if (win_len == '0) w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_spike_q <= 1'b1;
         r_win_cnt <= '0;
         r_acc     <= '0;
         r_sat     <= 1'b0;
      end else begin
         r_spike_q <= spike;
         if (w_restart) begin
            r_win_cnt <= win_len;
            r_acc     <= '0;
            r_sat     <= 1'b0;
         end else if (r_state == S_COUNT) begin
            r_win_cnt <= r_win_cnt - WIN_W'(1);
            r_acc     <= w_acc_inc;
            r_sat     <= r_sat | w_acc_ovf;
         end
      end
   end

   // ISI runs regardless of FSM state; the first edge only arms it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_since    <= '0;
         r_isi_last <= '0;
         r_seen1    <= 1'b0;
         r_seen2    <= 1'b0;
      end else if (w_event) begin
         r_since <= '0;
         r_seen1 <= 1'b1;
         if (r_seen1) begin
            r_isi_last <= (r_since == ISI_MAX) ? ISI_MAX : r_since + ISI_W'(1);
            r_seen2    <= 1'b1;
         end
      end else if (r_since != ISI_MAX) begin
         r_since <= r_since + ISI_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         rate      <= '0;
         isi       <= '0;
         isi_ok    <= 1'b0;
         rate_sat  <= 1'b0;
         overrun   <= 1'b0;
      end else if (w_last) begin
         out_valid <= 1'b1;
         rate      <= w_acc_inc;
         rate_sat  <= r_sat | w_acc_ovf;
         isi       <= r_isi_last;
         isi_ok    <= r_seen2;
         if (out_valid & ~out_ready) overrun <= 1'b1;
      end else if (w_hs) begin
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end
   end

endmodule
